// File: rtl/uart_frame_pkg.sv
// Shared types for the UART frame checker: FSM state encoding, parity modes
// and the expected-parity rule.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    EVEN  = 2'b00,
    ODD   = 2'b01,
    MARK  = 2'b10,
    SPACE = 2'b11
  } par_mode_e;

  // acc is the XOR of all data bits received so far.
  function automatic logic expected_parity(input par_mode_e mode, input logic acc);
    case (mode)
      EVEN:    return acc;
      ODD:     return ~acc;
      MARK:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/err_sat_cnt.sv
// Saturating error counter: counts inc pulses, holds at all-ones,
// synchronous clear has priority over increment.
module err_sat_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uart_frame_chk.sv
// UART receive frame checker: assembles LSB-first data, checks parity and
// stop bits against configuration latched at frame start, counts errors.
module uart_frame_chk
  import uart_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic                  STP_NUM,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  frame_done,
  output logic                  data_valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  localparam int BCW = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  par_mode_e             par_mode_q, par_mode_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic acc_q, acc_d, perr_q, perr_d, serr_q, serr_d;
  logic par_en_q, par_en_d, stp_num_q, stp_num_d;
  logic frame_done_q, frame_done_d, data_valid_q, data_valid_d;
  logic parity_error_q, parity_error_d, stop_error_q, stop_error_d;
  logic frame_end;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    par_mode_d     = par_mode_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    p_data_d       = p_data_q;
    acc_d          = acc_q;
    perr_d         = perr_q;
    serr_d         = serr_q;
    par_en_d       = par_en_q;
    stp_num_d      = stp_num_q;
    frame_done_d   = 1'b0;
    data_valid_d   = 1'b0;
    parity_error_d = parity_error_q;
    stop_error_d   = stop_error_q;
    frame_end      = 1'b0;

    // frame_start restarts from any state and swallows a coincident bit.
    if (frame_start) begin
      state_d    = ST_DATA;
      bit_cnt_d  = '0;
      acc_d      = 1'b0;
      perr_d     = 1'b0;
      serr_d     = 1'b0;
      par_en_d   = PAR_EN;
      par_mode_d = par_mode_e'(PAR_MODE);
      stp_num_d  = STP_NUM;
    end else if (bit_valid) begin
      case (state_q)
        ST_DATA: begin
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          acc_d     = acc_q ^ sampled_bit;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          perr_d  = (sampled_bit != expected_parity(par_mode_q, acc_q));
          state_d = ST_STOP1;
        end
        ST_STOP1: begin
          serr_d = serr_q | ~sampled_bit;
          if (stp_num_q) state_d = ST_STOP2;
          else           frame_end = 1'b1;
        end
        ST_STOP2: begin
          serr_d    = serr_q | ~sampled_bit;
          frame_end = 1'b1;
        end
        default: ;
      endcase
    end

    if (frame_end) begin
      state_d        = ST_IDLE;
      frame_done_d   = 1'b1;
      p_data_d       = shift_q;
      parity_error_d = perr_q;
      stop_error_d   = serr_d;
      data_valid_d   = ~perr_q & ~serr_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      par_mode_q     <= EVEN;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      p_data_q       <= '0;
      acc_q          <= 1'b0;
      perr_q         <= 1'b0;
      serr_q         <= 1'b0;
      par_en_q       <= 1'b0;
      stp_num_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      par_mode_q     <= par_mode_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      p_data_q       <= p_data_d;
      acc_q          <= acc_d;
      perr_q         <= perr_d;
      serr_q         <= serr_d;
      par_en_q       <= par_en_d;
      stp_num_q      <= stp_num_d;
      frame_done_q   <= frame_done_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  // Counters step on the same edge that raises frame_done.
  err_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (frame_end & perr_q),
    .clr   (err_clr),
    .count (par_err_cnt)
  );

  err_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (frame_end & serr_d),
    .clr   (err_clr),
    .count (stp_err_cnt)
  );

  assign P_DATA       = p_data_q;
  assign frame_done   = frame_done_q;
  assign data_valid   = data_valid_q;
  assign Parity_Error = parity_error_q;
  assign Stop_Error   = stop_error_q;

endmodule
